mem_stage: RTL and testbench

Memory stage of the pipeline, directly downstream of the execute stage. Latches the execute results into an EX/MEM register, performs word/half/byte loads and stores against an internal data memory, and registers the write-back result into a MEM/WB register. It also drives the two forwarding sources the execute stage consumes: `ALUResult_MEM` and `WriteData_WB`.

---
 rtl/mem_stage.sv | 144 ++++++++++++++
 tb/tb_mem_stage.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: EX/MEM register, data memory, MEM/WB register
// Optional misaligned-access trapping: define MEM_MISALIGN_CHECK_EN.
module mem_stage #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_BITS = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [31:0] ALUResult,
    input  logic [31:0] B_to_Signextend,
    input  logic [4:0]  destinationReg,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
    output logic [31:0] ALUResult_MEM,
    output logic [4:0]  DestReg_MEM,
    output logic        RegWrite_MEM,
    output logic [31:0] WriteData_WB,
    output logic [4:0]  DestReg_WB,
    output logic        RegWrite_WB,
    output logic        MisalignErr
);
    logic [31:0] alu_q, sd_q;
    logic [4:0]  dst_q;
    logic        rw_q, m2r_q, mr_q, mw_q, uns_q;
    logic [1:0]  size_q;

    // A flush must land even while stalled, so it bypasses the hold.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            alu_q  <= '0;
            sd_q   <= '0;
            dst_q  <= '0;
            rw_q   <= 1'b0;
            m2r_q  <= 1'b0;
            mr_q   <= 1'b0;
            mw_q   <= 1'b0;
            uns_q  <= 1'b0;
            size_q <= '0;
        end else if (Flush || !Stall) begin
            alu_q  <= ALUResult;
            sd_q   <= B_to_Signextend;
            dst_q  <= destinationReg;
            rw_q   <= RegWrite & ~Flush;
            m2r_q  <= MemtoReg;
            mr_q   <= MemRead & ~Flush;
            mw_q   <= MemWrite & ~Flush;
            uns_q  <= MemUnsigned;
            size_q <= MemSize;
        end
    end

    logic [ADDR_BITS-1:0] widx;
    logic [1:0]           raw_off, off;
    logic                 is_byte, is_half, is_word, misalign;

    assign widx    = alu_q[ADDR_BITS+1:2];
    assign raw_off = alu_q[1:0];
    assign is_byte = (size_q == 2'b10);
    assign is_half = (size_q == 2'b01);
    assign is_word = !is_byte && !is_half;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = (mr_q | mw_q) &
                      ((is_half & raw_off[0]) | (is_word & (raw_off != 2'b00)));
    assign off      = raw_off;
`else
    assign misalign = 1'b0;
    assign off      = is_byte ? raw_off : (is_half ? {raw_off[1], 1'b0} : 2'b00);
`endif

    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] rdata, load_data, wdata, bit_mask, new_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  lane_mask;

    assign rdata = mem_q[widx];

    always_comb begin
        byte_sel  = rdata[7:0];
        half_sel  = off[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        lane_mask = 4'b1111;
        wdata     = sd_q;
        case (off)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        if (is_byte) begin
            load_data = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            lane_mask = 4'b0001 << off;
            wdata     = {4{sd_q[7:0]}};
        end else if (is_half) begin
            load_data = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            lane_mask = off[1] ? 4'b1100 : 4'b0011;
            wdata     = {2{sd_q[15:0]}};
        end
        if (misalign) load_data = '0;
        bit_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
        new_word = (rdata & ~bit_mask) | (wdata & bit_mask);
    end

    // Contents survive reset; the async reset already cleared mw_q, discarding any pending store.
    always_ff @(posedge Clk) begin
        if (Rst && mw_q && !Stall && !misalign) mem_q[widx] <= new_word;
    end

    logic [31:0] wb_data_d, wb_data_q;
    logic [4:0]  wb_dst_q;
    logic        wb_rw_d, wb_rw_q, err_q;

    assign wb_data_d = m2r_q ? load_data : alu_q;
    assign wb_rw_d   = rw_q & ~(mr_q & misalign);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wb_data_q <= '0;
            wb_dst_q  <= '0;
            wb_rw_q   <= 1'b0;
            err_q     <= 1'b0;
        end else if (!Stall) begin
            wb_data_q <= wb_data_d;
            wb_dst_q  <= dst_q;
            wb_rw_q   <= wb_rw_d;
            err_q     <= misalign;
        end
    end

    assign ALUResult_MEM = alu_q;
    assign DestReg_MEM   = dst_q;
    assign RegWrite_MEM  = rw_q;
    assign WriteData_WB  = wb_data_q;
    assign DestReg_WB    = wb_dst_q;
    assign RegWrite_WB   = wb_rw_q;
    assign MisalignErr   = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage
module tb_mem_stage;
    logic        Clk = 1'b0;
    logic        Rst, Stall, Flush;
    logic [31:0] ALUResult, B_to_Signextend;
    logic [4:0]  destinationReg;
    logic        RegWrite, MemtoReg, MemRead, MemWrite, MemUnsigned;
    logic [1:0]  MemSize;
    logic [31:0] ALUResult_MEM, WriteData_WB;
    logic [4:0]  DestReg_MEM, DestReg_WB;
    logic        RegWrite_MEM, RegWrite_WB, MisalignErr;

    mem_stage dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
        .ALUResult(ALUResult), .B_to_Signextend(B_to_Signextend),
        .destinationReg(destinationReg), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
        .MemUnsigned(MemUnsigned), .ALUResult_MEM(ALUResult_MEM),
        .DestReg_MEM(DestReg_MEM), .RegWrite_MEM(RegWrite_MEM),
        .WriteData_WB(WriteData_WB), .DestReg_WB(DestReg_WB),
        .RegWrite_WB(RegWrite_WB), .MisalignErr(MisalignErr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dst;
        logic        rw;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam logic [31:0] MIS_DATA = 32'h0;
    localparam logic        MIS_RW   = 1'b0;
    localparam logic        MIS_ERR  = 1'b1;
`else
    localparam logic [31:0] MIS_DATA = 32'hA5A580EF;
    localparam logic        MIS_RW   = 1'b1;
    localparam logic        MIS_ERR  = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dst,
                         input logic rw, input logic m2r, input logic mr, input logic mw,
                         input logic [1:0] size, input logic uns, input logic flush,
                         input logic [31:0] exp_data, input logic exp_rw, input logic exp_err);
        exp_t e, got;
        ALUResult = alu; B_to_Signextend = sd; destinationReg = dst;
        RegWrite = rw; MemtoReg = m2r; MemRead = mr; MemWrite = mw;
        MemSize = size; MemUnsigned = uns; Flush = flush;
        e.data = exp_data; e.dst = dst; e.rw = exp_rw & ~flush;
        e.err = exp_err & ~flush; e.chk_data = ~flush;
        sb.push_back(e);
        @(posedge Clk); #1;
        Flush = 1'b0;
        check("RegWrite_MEM", {31'b0, RegWrite_MEM}, {31'b0, rw & ~flush});
        if (!flush) begin
            check("ALUResult_MEM", ALUResult_MEM, alu);
            check("DestReg_MEM", {27'b0, DestReg_MEM}, {27'b0, dst});
        end
        if (sb.size() == 2) begin
            got = sb.pop_front();
            if (got.chk_data) begin
                check("WriteData_WB", WriteData_WB, got.data);
                check("DestReg_WB", {27'b0, DestReg_WB}, {27'b0, got.dst});
            end
            check("RegWrite_WB", {31'b0, RegWrite_WB}, {31'b0, got.rw});
            check("MisalignErr", {31'b0, MisalignErr}, {31'b0, got.err});
        end
    endtask

    task automatic stall_cycles(input int n, input logic [31:0] alu_exp, input logic [31:0] wb_exp);
        Stall = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1;
            check("stall ALUResult_MEM", ALUResult_MEM, alu_exp);
            check("stall WriteData_WB", WriteData_WB, wb_exp);
            check("stall RegWrite_WB", {31'b0, RegWrite_WB}, 32'd1);
        end
        Stall = 1'b0;
    endtask

    initial begin
        Rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ALUResult = $urandom; B_to_Signextend = $urandom;
            destinationReg = 5'($urandom); MemSize = 2'($urandom);
            {RegWrite, MemtoReg, MemRead, MemWrite, MemUnsigned} = 5'($urandom);
            @(posedge Clk); #1;
            check("reset MEM outs", ALUResult_MEM | {27'b0, DestReg_MEM} | {31'b0, RegWrite_MEM}, 32'h0);
            check("reset WB outs", WriteData_WB | {27'b0, DestReg_WB} |
                  {30'b0, RegWrite_WB, MisalignErr}, 32'h0);
        end
        Rst = 1'b1;

        //     alu           sd            dst rw m2r mr mw size  uns fl  exp_data      rw  err
        issue(32'h1234,     32'h0,        3,  1, 0,  0, 0, 2'b00, 0, 0, 32'h1234,     1, 0);
        issue(32'h40,       32'hDEADBEEF, 0,  0, 0,  0, 1, 2'b00, 0, 0, 32'h40,       0, 0);
        issue(32'h40,       32'h0,        5,  1, 1,  1, 0, 2'b00, 0, 0, 32'hDEADBEEF, 1, 0);
        issue(32'h41,       32'h12345680, 0,  0, 0,  0, 1, 2'b10, 0, 0, 32'h41,       0, 0);
        issue(32'h41,       32'h0,        6,  1, 1,  1, 0, 2'b10, 0, 0, 32'hFFFFFF80, 1, 0);
        issue(32'h41,       32'h0,        6,  1, 1,  1, 0, 2'b10, 1, 0, 32'h00000080, 1, 0);
        issue(32'h40,       32'h0,        7,  1, 1,  1, 0, 2'b00, 0, 0, 32'hDEAD80EF, 1, 0);
        issue(32'h42,       32'h0000A5A5, 0,  0, 0,  0, 1, 2'b01, 0, 0, 32'h42,       0, 0);
        stall_cycles(3, 32'h42, 32'hDEAD80EF);
        issue(32'h40,       32'h0,        8,  1, 1,  1, 0, 2'b00, 0, 0, 32'hA5A580EF, 1, 0);
        issue(32'h42,       32'h0,        9,  1, 1,  1, 0, 2'b01, 0, 0, 32'hFFFFA5A5, 1, 0);
        issue(32'h40,       32'h0,        10, 1, 1,  1, 0, 2'b01, 1, 0, 32'h000080EF, 1, 0);
        issue(32'h40,       32'h0,        11, 1, 0,  0, 1, 2'b00, 0, 1, 32'h0,        0, 0);
        issue(32'h40,       32'h0,        12, 1, 1,  1, 0, 2'b00, 0, 0, 32'hA5A580EF, 1, 0);
        issue(32'h42,       32'h0,        13, 1, 1,  1, 0, 2'b00, 0, 0, MIS_DATA,     MIS_RW, MIS_ERR);
        issue(32'h1000_0044, 32'h0,       14, 1, 0,  0, 0, 2'b11, 0, 0, 32'h1000_0044, 1, 0);
        issue(32'h0,        32'h0,        0,  0, 0,  0, 0, 2'b00, 0, 0, 32'h0,        0, 0);
        issue(32'h0,        32'h0,        0,  0, 0,  0, 0, 2'b00, 0, 0, 32'h0,        0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
